// File: rtl/root_scheduler_if.sv
// Bundle of every handshake and data signal between the root scheduler, its
// two requesters, the root engine and the response consumer.
//   req_*  : two requesters (valid/ready, 10-bit radicand, 3-bit degree)
//   eng_*  : root engine input strobe/data and result strobe/data
//   rsp_*  : one-cycle response strobe with owner id, 20-bit result, error flag
// The slave modport is the scheduler's view; master is the environment's view.
interface root_scheduler_if;
    logic        req_valid_0;
    logic        req_valid_1;
    logic        req_ready_0;
    logic        req_ready_1;
    logic [9:0]  req_radicand_0;
    logic [9:0]  req_radicand_1;
    logic [2:0]  req_degree_0;
    logic [2:0]  req_degree_1;
    logic        eng_in_valid;
    logic [9:0]  eng_in_data_1;
    logic [2:0]  eng_in_data_2;
    logic        eng_out_valid;
    logic [19:0] eng_out_data;
    logic        rsp_valid;
    logic        rsp_id;
    logic [19:0] rsp_data;
    logic        rsp_err;

    modport slave (
        input  req_valid_0, req_valid_1,
        input  req_radicand_0, req_radicand_1,
        input  req_degree_0, req_degree_1,
        input  eng_out_valid, eng_out_data,
        output req_ready_0, req_ready_1,
        output eng_in_valid, eng_in_data_1, eng_in_data_2,
        output rsp_valid, rsp_id, rsp_data, rsp_err
    );

    modport master (
        output req_valid_0, req_valid_1,
        output req_radicand_0, req_radicand_1,
        output req_degree_0, req_degree_1,
        output eng_out_valid, eng_out_data,
        input  req_ready_0, req_ready_1,
        input  eng_in_valid, eng_in_data_1, eng_in_data_2,
        input  rsp_valid, rsp_id, rsp_data, rsp_err
    );
endinterface

// File: rtl/root_scheduler.sv
// Root scheduler: round-robin arbitration between two requesters, one job in
// flight at a time. A legal job (degree 1..5) is strobed into the root engine
// for ISSUE_CYC cycles, then the scheduler waits up to TIMEOUT cycles for the
// engine result; illegal degrees and timeouts answer with an error response.
// Ports:
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   bus   : root_scheduler_if.slave (requesters, engine, response)
//   busy  : high whenever the FSM is not IDLE
module root_scheduler #(
    parameter int TIMEOUT   = 127,
    parameter int ISSUE_CYC = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    root_scheduler_if.slave bus,
    output logic            busy
);
    localparam int WAIT_W  = ($clog2(TIMEOUT + 1) > 7) ? $clog2(TIMEOUT + 1) : 7;
    localparam int ISSUE_W = (ISSUE_CYC > 1) ? $clog2(ISSUE_CYC) : 1;
    localparam logic [WAIT_W-1:0]  WAIT_LAST  = WAIT_W'(TIMEOUT - 1);
    localparam logic [ISSUE_W-1:0] ISSUE_LAST = ISSUE_W'(ISSUE_CYC - 1);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    state_t             state;
    state_t             state_next;
    logic               rr_ptr;
    logic [ISSUE_W-1:0] issue_cnt;
    logic [WAIT_W-1:0]  wait_cnt;
    logic [9:0]         job_radicand;
    logic [2:0]         job_degree;
    logic               job_id;
    logic [19:0]        rsp_data_q;
    logic               rsp_id_q;
    logic               rsp_err_q;
    logic               grant_id;
    logic               accept;
    logic [2:0]         sel_degree;
    logic               sel_legal;
    logic               timeout_hit;

    // Arbiter: a lone requester always wins; rr_ptr only breaks ties.
    always_comb begin
        grant_id = 1'b0;
        if (bus.req_valid_0 && bus.req_valid_1) begin
            grant_id = rr_ptr;
        end else if (bus.req_valid_1) begin
            grant_id = 1'b1;
        end
    end

    assign accept      = (state == IDLE) && (bus.req_valid_0 || bus.req_valid_1);
    assign sel_degree  = grant_id ? bus.req_degree_1 : bus.req_degree_0;
    assign sel_legal   = (sel_degree >= 3'd1) && (sel_degree <= 3'd5);
    // Fires in the TIMEOUT-th WAIT cycle, i.e. as the counter would reach TIMEOUT.
    assign timeout_hit = (wait_cnt == WAIT_LAST);

    // Ready is gated with rst_n so it is low throughout reset.
    assign bus.req_ready_0 = rst_n && accept && !grant_id;
    assign bus.req_ready_1 = rst_n && accept && grant_id;

    assign bus.eng_in_data_1 = job_radicand;
    assign bus.eng_in_data_2 = job_degree;
    assign bus.rsp_data      = rsp_data_q;
    assign bus.rsp_id        = rsp_id_q;
    assign bus.rsp_err       = rsp_err_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // The engine result takes priority over a coincident timeout.
    always_comb begin
        state_next       = state;
        bus.eng_in_valid = 1'b0;
        bus.rsp_valid    = 1'b0;
        busy             = (state != IDLE);
        case (state)
            IDLE: begin
                if (accept) begin
                    state_next = sel_legal ? ISSUE : RESP;
                end
            end
            ISSUE: begin
                bus.eng_in_valid = 1'b1;
                if (issue_cnt == ISSUE_LAST) begin
                    state_next = WAIT;
                end
            end
            WAIT: begin
                if (bus.eng_out_valid || timeout_hit) begin
                    state_next = RESP;
                end
            end
            RESP: begin
                bus.rsp_valid = 1'b1;
                state_next    = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Job latch, counters and response registers. Response fields only change
    // on the edge that enters RESP, so they hold until the next response.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr       <= 1'b0;
            issue_cnt    <= '0;
            wait_cnt     <= '0;
            job_radicand <= '0;
            job_degree   <= '0;
            job_id       <= 1'b0;
            rsp_data_q   <= '0;
            rsp_id_q     <= 1'b0;
            rsp_err_q    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        job_radicand <= grant_id ? bus.req_radicand_1 : bus.req_radicand_0;
                        job_degree   <= sel_degree;
                        job_id       <= grant_id;
                        rr_ptr       <= ~grant_id;
                        issue_cnt    <= '0;
                        wait_cnt     <= '0;
                        if (!sel_legal) begin
                            rsp_data_q <= '0;
                            rsp_err_q  <= 1'b1;
                            rsp_id_q   <= grant_id;
                        end
                    end
                end
                ISSUE: begin
                    issue_cnt <= issue_cnt + ISSUE_W'(1);
                    wait_cnt  <= '0;
                end
                WAIT: begin
                    wait_cnt <= wait_cnt + WAIT_W'(1);
                    if (bus.eng_out_valid) begin
                        rsp_data_q <= bus.eng_out_data;
                        rsp_err_q  <= 1'b0;
                        rsp_id_q   <= job_id;
                    end else if (timeout_hit) begin
                        rsp_data_q <= '0;
                        rsp_err_q  <= 1'b1;
                        rsp_id_q   <= job_id;
                    end
                end
                default: begin
                end
            endcase
        end
    end
endmodule

// File: tb/tb_root_scheduler.sv
// Directed bench for root_scheduler (TIMEOUT=127, ISSUE_CYC=2).
// Main flow acts at negedge+1: drives inputs and checks outputs there.
// A negedge monitor counts engine strobes/responses and flags protocol breaks.
module tb_root_scheduler;
    logic clk;
    logic rst_n;
    logic busy;

    root_scheduler_if bus();

    root_scheduler #(.TIMEOUT(127), .ISSUE_CYC(2)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus),
        .busy  (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;
    int eng_in_cnt = 0;
    int rsp_cnt = 0;
    int ready_viol = 0;
    int data_viol = 0;
    logic [9:0] exp_rad = '0;
    logic [2:0] exp_deg = '0;

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic wait_ready(output int who);
        who = -1;
        for (int n = 0; n < 300; n++) begin
            if (bus.req_ready_0 || bus.req_ready_1) begin
                who = bus.req_ready_1 ? 1 : 0;
                break;
            end
            step();
        end
    endtask

    // Raise one requester, wait for its grant, pass the accept edge, drop valid.
    task automatic applyStimulus(input int id, input logic [9:0] rad, input logic [2:0] deg,
                                 output int who);
        if (id == 0) begin
            bus.req_valid_0 = 1'b1; bus.req_radicand_0 = rad; bus.req_degree_0 = deg;
        end else begin
            bus.req_valid_1 = 1'b1; bus.req_radicand_1 = rad; bus.req_degree_1 = deg;
        end
        #1;
        wait_ready(who);
        checkOutput("grant_id", who, id);
        exp_rad = rad;
        exp_deg = deg;
        step();
        bus.req_valid_0 = 1'b0;
        bus.req_valid_1 = 1'b0;
    endtask

    always @(negedge clk) begin
        if (bus.eng_in_valid) begin
            eng_in_cnt++;
            if (bus.eng_in_data_1 !== exp_rad || bus.eng_in_data_2 !== exp_deg) data_viol++;
        end
        if (bus.rsp_valid) rsp_cnt++;
        if (busy && (bus.req_ready_0 || bus.req_ready_1)) ready_viol++;
    end

    initial begin
        int who;
        int snap;
        int lat;
        bus.req_valid_0 = 1'b0; bus.req_valid_1 = 1'b0;
        bus.req_radicand_0 = '0; bus.req_radicand_1 = '0;
        bus.req_degree_0 = '0; bus.req_degree_1 = '0;
        bus.eng_out_valid = 1'b0; bus.eng_out_data = '0;
        rst_n = 1'b1;
        #2 rst_n = 1'b0;
        bus.req_valid_0 = 1'b1;
        step();
        step();
        checkOutput("rst_ready0", bus.req_ready_0, 0);
        checkOutput("rst_busy", busy, 0);
        checkOutput("rst_rsp_valid", bus.rsp_valid, 0);
        checkOutput("rst_eng_valid", bus.eng_in_valid, 0);
        checkOutput("rst_eng_d1", bus.eng_in_data_1, 0);
        checkOutput("rst_rsp_data", bus.rsp_data, 0);
        checkOutput("rst_rsp_err", bus.rsp_err, 0);
        bus.req_valid_0 = 1'b0;
        rst_n = 1'b1;
        step();

        $display("[TB] round-robin with both requesters valid");
        bus.req_valid_0 = 1'b1; bus.req_radicand_0 = 10'd100; bus.req_degree_0 = 3'd2;
        bus.req_valid_1 = 1'b1; bus.req_radicand_1 = 10'd200; bus.req_degree_1 = 3'd3;
        #1;
        for (int k = 0; k < 4; k++) begin
            wait_ready(who);
            checkOutput("rr_grant", who, k % 2);
            checkOutput("rr_one_ready", int'(bus.req_ready_0) + int'(bus.req_ready_1), 1);
            exp_rad = (who == 1) ? 10'd200 : 10'd100;
            exp_deg = (who == 1) ? 3'd3 : 3'd2;
            step();
            checkOutput("rr_busy", busy, 1);
            step();
            step();
            bus.eng_out_valid = 1'b1;
            bus.eng_out_data = 20'h00100 * (k + 1);
            step();
            bus.eng_out_valid = 1'b0;
            checkOutput("rr_rsp_valid", bus.rsp_valid, 1);
            checkOutput("rr_rsp_id", bus.rsp_id, k % 2);
            checkOutput("rr_rsp_data", bus.rsp_data, 20'h00100 * (k + 1));
            step();
        end
        bus.req_valid_0 = 1'b0;
        bus.req_valid_1 = 1'b0;
        step();

        $display("[TB] basic job 64/2");
        snap = eng_in_cnt;
        applyStimulus(0, 10'd64, 3'd2, who);
        checkOutput("b_eng_valid1", bus.eng_in_valid, 1);
        checkOutput("b_eng_d1", bus.eng_in_data_1, 64);
        checkOutput("b_eng_d2", bus.eng_in_data_2, 2);
        step();
        checkOutput("b_eng_valid2", bus.eng_in_valid, 1);
        step();
        checkOutput("b_eng_valid3", bus.eng_in_valid, 0);
        repeat (17) step();
        bus.eng_out_valid = 1'b1;
        bus.eng_out_data = 20'h02000;
        step();
        bus.eng_out_valid = 1'b0;
        checkOutput("b_rsp_valid", bus.rsp_valid, 1);
        checkOutput("b_rsp_id", bus.rsp_id, 0);
        checkOutput("b_rsp_data", bus.rsp_data, 20'h02000);
        checkOutput("b_rsp_err", bus.rsp_err, 0);
        checkOutput("b_issue_len", eng_in_cnt - snap, 2);
        step();
        checkOutput("b_rsp_pulse", bus.rsp_valid, 0);
        checkOutput("b_busy_idle", busy, 0);
        checkOutput("b_rsp_hold", bus.rsp_data, 20'h02000);

        $display("[TB] illegal degrees 0 and 7");
        snap = eng_in_cnt;
        applyStimulus(1, 10'd5, 3'd0, who);
        checkOutput("ill0_rsp_valid", bus.rsp_valid, 1);
        checkOutput("ill0_rsp_err", bus.rsp_err, 1);
        checkOutput("ill0_rsp_data", bus.rsp_data, 0);
        checkOutput("ill0_rsp_id", bus.rsp_id, 1);
        step();
        applyStimulus(1, 10'd9, 3'd7, who);
        checkOutput("ill7_rsp_valid", bus.rsp_valid, 1);
        checkOutput("ill7_rsp_err", bus.rsp_err, 1);
        checkOutput("ill7_rsp_data", bus.rsp_data, 0);
        checkOutput("ill_no_issue", eng_in_cnt - snap, 0);
        step();

        $display("[TB] silent engine timeout");
        applyStimulus(0, 10'd100, 3'd3, who);
        lat = 1;
        while (!bus.rsp_valid && lat < 300) begin
            step();
            lat++;
        end
        checkOutput("to_latency", lat, 130);
        checkOutput("to_rsp_err", bus.rsp_err, 1);
        checkOutput("to_rsp_data", bus.rsp_data, 0);
        bus.eng_out_valid = 1'b1;
        bus.eng_out_data = 20'h12345;
        step();
        step();
        bus.eng_out_valid = 1'b0;
        checkOutput("late_rsp_valid", bus.rsp_valid, 0);
        checkOutput("late_busy", busy, 0);
        checkOutput("late_rsp_data", bus.rsp_data, 0);
        applyStimulus(1, 10'd27, 3'd3, who);
        step();
        step();
        bus.eng_out_valid = 1'b1;
        bus.eng_out_data = 20'h00C00;
        step();
        bus.eng_out_valid = 1'b0;
        checkOutput("after_to_valid", bus.rsp_valid, 1);
        checkOutput("after_to_err", bus.rsp_err, 0);
        checkOutput("after_to_data", bus.rsp_data, 20'h00C00);
        checkOutput("after_to_id", bus.rsp_id, 1);
        step();

        $display("[TB] result in the timeout cycle");
        applyStimulus(0, 10'd512, 3'd5, who);
        repeat (128) step();
        checkOutput("edge_busy", busy, 1);
        checkOutput("edge_no_rsp", bus.rsp_valid, 0);
        bus.eng_out_valid = 1'b1;
        bus.eng_out_data = 20'h0ABCD;
        step();
        bus.eng_out_valid = 1'b0;
        checkOutput("edge_rsp_valid", bus.rsp_valid, 1);
        checkOutput("edge_rsp_err", bus.rsp_err, 0);
        checkOutput("edge_rsp_data", bus.rsp_data, 20'h0ABCD);
        step();

        $display("[TB] reset during WAIT");
        applyStimulus(0, 10'd300, 3'd4, who);
        repeat (5) step();
        snap = rsp_cnt;
        bus.req_valid_0 = 1'b1;
        bus.req_valid_1 = 1'b1;
        rst_n = 1'b0;
        #1;
        checkOutput("mid_rst_busy", busy, 0);
        checkOutput("mid_rst_rsp_valid", bus.rsp_valid, 0);
        checkOutput("mid_rst_eng_d1", bus.eng_in_data_1, 0);
        checkOutput("mid_rst_rsp_data", bus.rsp_data, 0);
        checkOutput("mid_rst_ready", {bus.req_ready_1, bus.req_ready_0}, 0);
        step();
        bus.req_valid_0 = 1'b0;
        bus.req_valid_1 = 1'b0;
        bus.eng_out_valid = 1'b1;
        bus.eng_out_data = 20'h00777;
        step();
        rst_n = 1'b1;
        step();
        bus.eng_out_valid = 1'b0;
        checkOutput("post_rst_busy", busy, 0);
        checkOutput("post_rst_rsp_data", bus.rsp_data, 0);
        step();
        checkOutput("post_rst_no_rsp", rsp_cnt - snap, 0);
        bus.req_valid_0 = 1'b1; bus.req_radicand_0 = 10'd77; bus.req_degree_0 = 3'd1;
        bus.req_valid_1 = 1'b1; bus.req_radicand_1 = 10'd88; bus.req_degree_1 = 3'd2;
        #1;
        wait_ready(who);
        checkOutput("post_rst_grant", who, 0);
        exp_rad = 10'd77;
        exp_deg = 3'd1;
        step();
        bus.req_valid_0 = 1'b0;
        bus.req_valid_1 = 1'b0;
        checkOutput("post_rst_issue", bus.eng_in_valid, 1);
        step();
        step();

        checkOutput("ready_outside_idle", ready_viol, 0);
        checkOutput("eng_data_stable", data_viol, 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/root_scheduler.md
ROOT_SCHEDULER -- requirements
Module: root_scheduler

Interface
REQ-001 The block SHALL have parameter TIMEOUT, default 127: maximum WAIT-state cycles before a job is aborted.
REQ-002 The block SHALL have parameter ISSUE_CYC, default 2: number of cycles eng_in_valid is held high per job.
REQ-003 The block SHALL use one clock and an asynchronous active-low reset; the clock and reset ports are defined in REQ-004 and REQ-005.
REQ-004 clk  in  1  single clock; all state updates on the rising edge.
REQ-005 rst_n  in  1  asynchronous active-low reset.
REQ-006 req_valid_0 / req_valid_1  in  1  requester 0/1 has a job pending.
REQ-007 req_ready_0 / req_ready_1  out  1  job from requester 0/1 accepted this cycle.
REQ-008 req_radicand_0 / req_radicand_1  in  10  radicand of requester 0/1.
REQ-009 req_degree_0 / req_degree_1  in  3  root degree of requester 0/1; legal range 1..5.
REQ-010 eng_in_valid  out  1  root engine input strobe.
REQ-011 eng_in_data_1  out  10  radicand driven to the engine.
REQ-012 eng_in_data_2  out  3  degree driven to the engine.
REQ-013 eng_out_valid  in  1  engine result strobe.
REQ-014 eng_out_data  in  20  engine result: 10 integer bits, 10 fraction bits.
REQ-015 rsp_valid  out  1  one-cycle response strobe.
REQ-016 rsp_id  out  1  requester that owns the response.
REQ-017 rsp_data  out  20  result.
REQ-018 rsp_err  out  1  response is an error (illegal degree or timeout).
REQ-019 busy  out  1  high whenever the state is not IDLE.

Function
REQ-020 The FSM SHALL have states IDLE, ISSUE, WAIT, RESP.
REQ-021 In IDLE, the arbiter SHALL grant the single requester whose req_valid is high; when both are high, it SHALL grant the requester not granted last (round-robin), and requester 0 wins after reset.
REQ-022 req_ready_x SHALL be combinational: high only in IDLE, and only for the granted requester.
REQ-023 The accept cycle is req_valid_x && req_ready_x; on accept, the block SHALL latch radicand, degree and id, and update the round-robin pointer.
REQ-024 If the accepted degree is 0, 6 or 7, the FSM SHALL go IDLE->RESP with rsp_err=1 and rsp_data=0, and eng_in_valid SHALL never assert for that job.
REQ-025 If the accepted degree is legal, the FSM SHALL go IDLE->ISSUE; in ISSUE, eng_in_valid SHALL be 1 for exactly ISSUE_CYC cycles with eng_in_data_1/2 stable, then the FSM SHALL go to WAIT.
REQ-026 eng_in_data_1/2 SHALL hold the latched job values from ISSUE until the next accept; eng_in_valid SHALL be 0 outside ISSUE.
REQ-027 In WAIT, a 7-bit-minimum counter SHALL start at 0 and increment each cycle; when eng_out_valid=1, the block SHALL capture eng_out_data and go to RESP with rsp_err=0.
REQ-028 If the WAIT counter reaches TIMEOUT with no eng_out_valid, the FSM SHALL go to RESP with rsp_err=1 and rsp_data=0.
REQ-029 If eng_out_valid and the timeout occur in the same cycle, the result SHALL win (rsp_err=0).
REQ-030 eng_out_valid SHALL be ignored in every state other than WAIT, including a late result after a timeout.
REQ-031 In RESP, rsp_valid SHALL be 1 for exactly one cycle, with rsp_id/rsp_data/rsp_err valid in that cycle; the FSM SHALL then return to IDLE.
REQ-032 rsp_data/rsp_id/rsp_err SHALL hold their values until the next RESP.
REQ-033 Minimum accept-to-rsp_valid latency SHALL be 1 + ISSUE_CYC + 1 + engine latency cycles, and 1 cycle for an illegal degree.
REQ-034 The next accept SHALL be possible in the cycle after RESP; no job is ever queued, and a requester holds req_valid until ready.

Reset
REQ-035 On rst_n=0, the block SHALL asynchronously force state=IDLE, round-robin pointer to favour requester 0, WAIT counter=0, and all latched job fields=0.
REQ-036 While rst_n=0, all outputs SHALL be 0, including req_ready_x and busy.
REQ-037 A reset asserted mid-job SHALL abort the job with no response; after release, the first eng_out_valid SHALL be ignored unless the FSM is in WAIT.

Verification
REQ-038 Req0: radicand 64, degree 2; engine model returns 20'h02000 after 20 cycles -> eng_in_valid high 2 cycles with data 64/2; rsp_valid with id 0, data 20'h02000, err 0.
REQ-039 Both requesters valid every cycle, 4 jobs -> grants alternate 0,1,0,1; exactly one req_ready per accept; no ready outside IDLE.
REQ-040 Req1: degree 0, then degree 7 -> rsp_err=1 with data 0 one cycle after each accept; eng_in_valid never asserts.
REQ-041 Engine silent -> rsp_err=1 after TIMEOUT=127 WAIT cycles; an injected late eng_out_valid is ignored; the next job completes normally.
REQ-042 Engine result lands in the exact timeout cycle -> rsp_err=0 with the captured data.
REQ-043 rst_n pulsed low during WAIT -> outputs 0 immediately, no rsp_valid, busy=0; the following job from req0 is granted first.
